ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader.sv | 169 ++++++++++++++++
 tb/tb_ram_burst_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: turns (address, length) burst commands into a stream of
// RAM rows. Reads are issued against a one-cycle-latency RAM port and land in
// a 2-entry output buffer; a credit check on issue keeps that buffer from
// overflowing while still sustaining one row per cycle under full throughput.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a command; cmdReady_out high (outside reset)
// S_BURST | issuing one read per cycle while credit allows
module ram_burst_reader #(
  parameter int ADDR_NBITS = 5,
  parameter int SPAN_NBITS = 8
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic [ADDR_NBITS-1:0]     cmdAddr_in,
  input  logic [ADDR_NBITS-1:0]     cmdLen_in,
  input  logic                      cmdValid_in,
  output logic                      cmdReady_out,
  output logic [ADDR_NBITS-1:0]     rdAddr_out,
  input  logic [SPAN_NBITS*8-1:0]   rdData_in,
  output logic [SPAN_NBITS*8-1:0]   rspData_out,
  output logic                      rspLast_out,
  output logic                      rspValid_out,
  input  logic                      rspReady_in
);

  localparam int DATA_NBITS = SPAN_NBITS * 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Burst bookkeeping
  logic [ADDR_NBITS-1:0] addr_cnt;
  logic [ADDR_NBITS-1:0] remain;
  logic [ADDR_NBITS-1:0] rd_addr_q;

  // A read issued last cycle; its data is on rdData_in this cycle
  logic in_flight;
  logic in_flight_last;

  // Two-entry output buffer
  logic [DATA_NBITS-1:0] buf_data [2];
  logic [1:0]            buf_last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;

  // Handshake / control strobes
  logic       cmd_accept;
  logic       issue;
  logic       issue_last;
  logic       push;
  logic       pop;
  logic [2:0] credit_used;
  logic [2:0] credit_limit;

  // Output buffer head and handshakes; outputs are forced quiet during reset
  assign rspValid_out = (occ != 2'd0) && !reset_in;
  assign rspData_out  = buf_data[rd_ptr];
  assign rspLast_out  = rspValid_out && buf_last[rd_ptr];
  assign cmdReady_out = (state == S_IDLE) && !reset_in;

  assign pop  = rspValid_out && rspReady_in;
  assign push = in_flight;

  // A read may be issued when (inFlight + occupancy - pop) < 2; the pop is
  // moved to the right-hand side to keep the arithmetic unsigned.
  assign credit_used  = {2'b00, in_flight} + {1'b0, occ};
  assign credit_limit = 3'd2 + {2'b00, pop};

  // The address goes to the RAM in the issue cycle itself, otherwise the
  // last issued address is held so the port never floats.
  assign rdAddr_out = issue ? addr_cnt : rd_addr_q;

  // Next-state logic and per-cycle strobes
  always_comb begin
    state_nxt  = state;
    cmd_accept = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmdValid_in && !reset_in) begin
          cmd_accept = 1'b1;
          state_nxt  = S_BURST;
        end
      end
      S_BURST: begin
        if (!reset_in && (credit_used < credit_limit)) begin
          issue = 1'b1;
          if (remain == '0) begin
            issue_last = 1'b1;
            state_nxt  = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Address counter, remaining count, held read address and in-flight tag
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      addr_cnt       <= '0;
      remain         <= '0;
      rd_addr_q      <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= issue;
      in_flight_last <= issue_last;
      if (cmd_accept) begin
        addr_cnt <= cmdAddr_in;
        remain   <= cmdLen_in;
      end else if (issue) begin
        rd_addr_q <= addr_cnt;
        addr_cnt  <= addr_cnt + ADDR_NBITS'(1);
        if (remain != '0) begin
          remain <= remain - ADDR_NBITS'(1);
        end
      end
    end
  end

  // Buffer pointers and occupancy; push and pop together leave occupancy alone
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Buffer storage; contents are meaningless while occupancy is zero
  always_ff @(posedge clk_in) begin
    if (push) begin
      buf_data[wr_ptr] <= rdData_in;
      buf_last[wr_ptr] <= in_flight_last;
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: a behavioural one-cycle RAM holding
// row k = {8{k[7:0]}}, a scoreboard queue filled at each command handshake
// and drained as rows are accepted, and directed burst scenarios.
module tb_ram_burst_reader;

  localparam int AW = 5;
  localparam int SW = 8;
  localparam int DW = SW * 8;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic [AW-1:0] cmdAddr_in;
  logic [AW-1:0] cmdLen_in;
  logic          cmdValid_in;
  logic          cmdReady_out;
  logic [AW-1:0] rdAddr_out;
  logic [DW-1:0] rdData_in;
  logic [DW-1:0] rspData_out;
  logic          rspLast_out;
  logic          rspValid_out;
  logic          rspReady_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW:0] sb [$];

  int first_valid_cyc = -1;
  int pop_first = 0;
  int pop_last  = 0;
  int pop_n     = 0;

  logic ready_cmd = 1'b1;
  logic bp_mode   = 1'b0;
  int   bp_cyc    = 0;
  int   stall_left = 0;

  always #5 clk_in = ~clk_in;

  ram_burst_reader #(.ADDR_NBITS(AW), .SPAN_NBITS(SW)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .cmdAddr_in   (cmdAddr_in),
    .cmdLen_in    (cmdLen_in),
    .cmdValid_in  (cmdValid_in),
    .cmdReady_out (cmdReady_out),
    .rdAddr_out   (rdAddr_out),
    .rdData_in    (rdData_in),
    .rspData_out  (rspData_out),
    .rspLast_out  (rspLast_out),
    .rspValid_out (rspValid_out),
    .rspReady_in  (rspReady_in)
  );

  function automatic logic [DW-1:0] row_val(input int k);
    logic [7:0] b;
    b = 8'(k % (1 << AW));
    return {8{b}};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM model: data for the address presented this cycle appears next cycle
  always @(posedge clk_in) rdData_in <= row_val(int'(rdAddr_out));

  // Consumer ready: follows ready_cmd, or a pseudo-random pattern with forced 5-cycle stalls
  always @(posedge clk_in) begin
    #1;
    if (bp_mode) begin
      bp_cyc++;
      if (stall_left > 0) begin
        stall_left--;
        rspReady_in = 1'b0;
      end else if (bp_cyc == 5 || bp_cyc == 16) begin
        stall_left = 4;
        rspReady_in = 1'b0;
      end else begin
        rspReady_in = ($urandom_range(0, 2) != 0);
      end
    end else begin
      bp_cyc = 0;
      rspReady_in = ready_cmd;
    end
  end

  // Output monitor: every offered row must match the scoreboard head
  always @(negedge clk_in) begin
    if (!reset_in) begin
      check("rdaddr_known", 64'($isunknown(rdAddr_out)), 64'd0);
      check("occ_le2", 64'(dut.occ <= 2'd2), 64'd1);
      if (rspValid_out) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_valid", 64'(rspValid_out), 64'd0);
        end else begin
          check("rsp_data", rspData_out, sb[0][DW-1:0]);
          check("rsp_last", 64'(rspLast_out), 64'(sb[0][DW]));
          if (rspReady_in) begin
            void'(sb.pop_front());
            if (pop_n == 0) pop_first = cyc;
            pop_last = cyc;
            pop_n++;
          end
        end
      end
    end
  end

  task automatic clr_stats();
    first_valid_cyc = -1;
    pop_n = 0;
    pop_first = 0;
    pop_last = 0;
  endtask

  task automatic send_cmd(input int a, input int l, output int hs);
    int n;
    logic [DW:0] e;
    logic got;
    got = 1'b0;
    n = 0;
    hs = -1;
    @(posedge clk_in); #1;
    cmdAddr_in  = AW'(a);
    cmdLen_in   = AW'(l);
    cmdValid_in = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk_in);
      if (cmdReady_out) got = 1'b1;
      n++;
    end
    if (!got) begin
      check("cmd_timeout", 64'(cmdReady_out), 64'd1);
    end else begin
      hs = cyc;
      for (int i = 0; i <= l; i++) begin
        e = {1'(i == l), row_val(a + i)};
        sb.push_back(e);
      end
    end
    @(posedge clk_in); #1;
    cmdValid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rspValid_out) && n < 300) begin
      @(posedge clk_in); #2;
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, hs1, hs2;
    reset_in    = 1'b1;
    cmdValid_in = 1'b0;
    cmdAddr_in  = '0;
    cmdLen_in   = '0;

    // Reset state
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_valid", 64'(rspValid_out), 64'd0);
    check("rst_last", 64'(rspLast_out), 64'd0);
    check("rst_cmd_ready", 64'(cmdReady_out), 64'd0);
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_cmd_ready", 64'(cmdReady_out), 64'd1);
    check("post_rst_rdaddr", 64'(rdAddr_out), 64'd0);

    // Single row, latency
    clr_stats();
    send_cmd(3, 0, hs);
    wait_drain();
    check("t1_latency", 64'(first_valid_cyc - hs), 64'd3);
    check("t1_rows", 64'(pop_n), 64'd1);

    // Streaming burst
    clr_stats();
    send_cmd(4, 7, hs);
    wait_drain();
    check("t2_rows", 64'(pop_n), 64'd8);
    check("t2_consecutive", 64'(pop_last - pop_first), 64'd7);
    check("t2_latency", 64'(first_valid_cyc - hs), 64'd3);

    // Address wrap
    clr_stats();
    send_cmd(30, 3, hs);
    wait_drain();
    check("t3_rows", 64'(pop_n), 64'd4);

    // Backpressure
    clr_stats();
    bp_mode = 1'b1;
    send_cmd(0, 9, hs);
    wait_drain();
    bp_mode = 1'b0;
    check("t4_rows", 64'(pop_n), 64'd10);

    // Back-to-back commands
    clr_stats();
    send_cmd(8, 1, hs1);
    send_cmd(20, 1, hs2);
    check("t5_accept_gap", 64'(hs2 - hs1), 64'd3);
    wait_drain();
    check("t5_rows", 64'(pop_n), 64'd4);

    // Reset mid-burst: third issue at hs+3, reset high from hs+4
    clr_stats();
    send_cmd(0, 15, hs);
    repeat (3) @(posedge clk_in);
    #1;
    reset_in = 1'b1;
    sb.delete();
    @(negedge clk_in);
    check("t6_rst_valid", 64'(rspValid_out), 64'd0);
    check("t6_rst_cmd_ready", 64'(cmdReady_out), 64'd0);
    check("t6_rst_last", 64'(rspLast_out), 64'd0);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    @(negedge clk_in);
    check("t6_cmd_ready", 64'(cmdReady_out), 64'd1);
    check("t6_rdaddr", 64'(rdAddr_out), 64'd0);
    check("t6_no_stale", 64'(rspValid_out), 64'd0);
    repeat (8) @(posedge clk_in);
    #1;
    clr_stats();
    send_cmd(2, 0, hs);
    wait_drain();
    check("t6_rows", 64'(pop_n), 64'd1);
    check("t6_latency", 64'(first_valid_cyc - hs), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
